gol_matrix_scanner: RTL and testbench

//  Downstream display stage for the Game of Life datapath. Consumes the 64-bit

---
 rtl/gol_matrix_scanner_pkg.sv | 18 +
 rtl/gol_matrix_scanner_if.sv | 37 +++
 rtl/gol_matrix_scanner_popcount.sv | 27 ++
 rtl/gol_matrix_scanner.sv | 109 ++++++++++
 tb/tb_gol_matrix_scanner.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/gol_matrix_scanner_pkg.sv
// ============================================================================
// Module     : gol_matrix_scanner_pkg
// Description: Shared Game of Life grid geometry used by the scanner and datapath.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package gol_matrix_scanner_pkg;

  localparam int GOL_ROWS  = 8;
  localparam int GOL_COLS  = 8;
  localparam int GOL_CELLS = GOL_ROWS * GOL_COLS;
  localparam int GOL_CNT_W = 7;

endpackage

`default_nettype wire

// File: rtl/gol_matrix_scanner_if.sv
// ============================================================================
// Module     : gol_matrix_scanner_if
// Description: Grid input and LED matrix output bundle of the row scanner.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface gol_matrix_scanner_if
  import gol_matrix_scanner_pkg::*;
#(
  parameter int ROWS  = GOL_ROWS,
  parameter int COLS  = GOL_COLS,
  parameter int CNT_W = GOL_CNT_W
) ();

  logic [ROWS*COLS-1:0] grid;
  logic                 load;
  logic                 blank;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      col_data;
  logic [CNT_W-1:0]     alive_count;
  logic                 frame_sync;

  modport master (
    output grid, load, blank,
    input  row_sel, col_data, alive_count, frame_sync
  );

  modport slave (
    input  grid, load, blank,
    output row_sel, col_data, alive_count, frame_sync
  );

endinterface

`default_nettype wire

// File: rtl/gol_matrix_scanner_popcount.sv
// ============================================================================
// Module     : gol_popcount
// Description: Combinational population count of one matrix row.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gol_popcount #(
  parameter int W = 8
) (
  input  wire logic [W-1:0]             bits,
  output logic      [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gol_matrix_scanner.sv
// ============================================================================
// Module     : gol_matrix_scanner
// Description: Double-buffered 8x8 LED row scanner with per-frame live-cell count.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gol_matrix_scanner
  import gol_matrix_scanner_pkg::*;
#(
  parameter int ROWS = GOL_ROWS,
  parameter int COLS = GOL_COLS,
  parameter int DIV  = 4
) (
  input  wire logic          clka,
  input  wire logic          rst_n,
  gol_matrix_scanner_if.slave bus
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PC_W  = $clog2(COLS + 1);
  localparam int CNT_W = GOL_CNT_W;

  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(DIV - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(ROWS - 1);

  logic [PRE_W-1:0]     r_pre;
  logic [ROW_W-1:0]     r_row;
  logic [ROWS*COLS-1:0] r_shadow;
  logic [ROWS*COLS-1:0] r_staging;
  logic                 r_pending;
  logic [CNT_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_alive;
  logic [ROWS-1:0]      r_row_sel;
  logic [COLS-1:0]      r_col_data;
  logic                 r_frame_sync;

  logic                 w_row_tick;
  logic                 w_frame_end;
  logic                 w_swap;
  logic [COLS-1:0]      w_row_bits;
  logic [PC_W-1:0]      w_row_pop;
  logic [CNT_W-1:0]     w_acc_next;

  assign w_row_tick  = (r_pre == c_pre_last);
  assign w_frame_end = w_row_tick && (r_row == c_row_last);
  assign w_swap      = w_frame_end && (r_pending || bus.load);
  assign w_row_bits  = r_shadow[r_row*COLS +: COLS];
  assign w_acc_next  = r_acc + CNT_W'(w_row_pop);

  gol_popcount #(
    .W (COLS)
  ) u_popcount (
    .bits  (w_row_bits),
    .count (w_row_pop)
  );

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_row        <= '0;
      r_shadow     <= '0;
      r_staging    <= '0;
      r_pending    <= 1'b0;
      r_acc        <= '0;
      r_alive      <= '0;
      r_row_sel    <= '1;
      r_col_data   <= '0;
      r_frame_sync <= 1'b0;
    end else begin
      r_pre <= w_row_tick ? '0 : r_pre + 1'b1;
      if (w_row_tick) begin
        r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
      end

      if (bus.load) begin
        r_staging <= bus.grid;
        r_pending <= 1'b1;
      end
      // A load landing exactly on frame_end is consumed by this swap directly.
      if (w_swap) begin
        r_shadow  <= bus.load ? bus.grid : r_staging;
        r_pending <= 1'b0;
      end
      r_frame_sync <= w_swap;

      // Count reflects the shadow as it was displayed, before any swap.
      if (w_frame_end) begin
        r_alive <= w_acc_next;
        r_acc   <= '0;
      end else if (w_row_tick) begin
        r_acc <= w_acc_next;
      end

      r_row_sel  <= bus.blank ? '1 : ~(ROWS'(1) << r_row);
      r_col_data <= bus.blank ? '0 : w_row_bits;
    end
  end

  assign bus.row_sel     = r_row_sel;
  assign bus.col_data    = r_col_data;
  assign bus.alive_count = r_alive;
  assign bus.frame_sync  = r_frame_sync;

endmodule

`default_nettype wire

// File: tb/tb_gol_matrix_scanner.sv
// ============================================================================
// Module     : tb_gol_matrix_scanner
// Description: Scoreboard bench for the row scanner against a frame-level model.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gol_matrix_scanner;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DIV   = 4;
  localparam int FRAME = ROWS * DIV;

  typedef struct packed {
    logic [7:0] rs;
    logic [7:0] cd;
    logic [6:0] ac;
    logic       fs;
  } exp_t;

  logic clka  = 1'b0;
  logic rst_n = 1'b0;

  always #5 clka = ~clka;

  gol_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  gol_matrix_scanner #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DIV  (DIV)
  ) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: frame position derives from cycles since reset.
  logic [63:0] m_shadow;
  logic [63:0] m_staging;
  logic        m_pending;
  logic [6:0]  m_alive;
  int          t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input logic rn, input logic ld, input logic bl, input logic [63:0] g);
    exp_t e;
    int   row;
    bit   fe;
    @(negedge clka);
    rst_n     = rn;
    bus.load  = ld;
    bus.blank = bl;
    bus.grid  = g;
    if (!rn) begin
      e         = '{rs: 8'hFF, cd: 8'h00, ac: 7'd0, fs: 1'b0};
      m_shadow  = '0;
      m_staging = '0;
      m_pending = 1'b0;
      m_alive   = '0;
      t         = 0;
    end else begin
      row  = (t / DIV) % ROWS;
      fe   = (t % FRAME) == FRAME - 1;
      e.rs = bl ? 8'hFF : ~(8'd1 << row);
      e.cd = bl ? 8'h00 : m_shadow[row*8 +: 8];
      e.fs = fe && (m_pending || ld);
      if (fe) m_alive = 7'($countones(m_shadow));
      e.ac = m_alive;
      if (fe && (m_pending || ld)) begin
        m_shadow  = ld ? g : m_staging;
        m_pending = 1'b0;
        if (ld) m_staging = g;
      end else if (ld) begin
        m_staging = g;
        m_pending = 1'b1;
      end
      t++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  function automatic logic [63:0] rgrid();
    case ($urandom % 4)
      0:       return {$urandom, $urandom};
      1:       return 64'h0;
      2:       return 64'd1 << ($urandom % 64);
      default: return {$urandom, $urandom} & {$urandom, $urandom};
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clka);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("row_sel",     32'(bus.row_sel),     32'(e.rs));
        chk("col_data",    32'(bus.col_data),    32'(e.cd));
        chk("alive_count", 32'(bus.alive_count), 32'(e.ac));
        chk("frame_sync",  32'(bus.frame_sync),  32'(e.fs));
      end
    end
  end

  initial begin : driver
    bit bl;
    bit rn;
    bit ld;
    bus.grid  = '0;
    bus.load  = 1'b0;
    bus.blank = 1'b0;
    t         = 0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 64'h0);

    // Diagonal pattern scanned across several frames
    step(1'b1, 1'b1, 1'b0, 64'h8040201008040201);
    idle(3 * FRAME);

    // Load while row 3 is active must not tear the current frame
    while (((t / DIV) % ROWS) != 3) idle(1);
    step(1'b1, 1'b1, 1'b0, 64'h00000000000000FF);
    idle(3 * FRAME);

    // Two loads in one frame, last wins
    while ((t % FRAME) != 2) idle(1);
    step(1'b1, 1'b1, 1'b0, 64'h1);
    idle(5);
    step(1'b1, 1'b1, 1'b0, 64'h3);
    idle(2 * FRAME);

    // Load coincident with frame_end
    while ((t % FRAME) != FRAME - 1) idle(1);
    step(1'b1, 1'b1, 1'b0, 64'hF0F0_0F0F_AA55_FFFF);
    idle(2 * FRAME);

    // Blank mid-row, then release
    while ((t % DIV) != 1) idle(1);
    repeat (6) step(1'b1, 1'b0, 1'b1, 64'h0);
    idle(FRAME + 3);

    // Reset mid-frame with a pending load
    idle(9);
    step(1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    idle(2 * FRAME);

    // Randomized traffic
    bl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom % 600) != 0;
      ld = ($urandom % 10) == 0;
      if (($urandom % 40) == 0) bl = ~bl;
      step(rn, ld, bl, rgrid());
    end
    idle(2);

    @(posedge clka);
    #2;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
